// File: rtl/frame_scheduler.sv
// frame_scheduler: paces frame starts for a bank of ws2811 drivers and
// arbitrates their pixel-data requests onto one shared pixel memory.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   frame_ready[U]      pulse: universe pixel buffer fully loaded
//   drv_sending[U]      driver currently shifting out a frame
//   drv_request[U]      pulse: driver wants one pixel
//   drv_addr[U*8]       pixel index per universe, universe u at [8u+7:8u]
//   drv_start[U]        one-cycle frame start pulse per universe
//   mem_rd_en/univ/addr shared pixel-memory read port
//   mem_rd_data         memory data, valid one cycle after mem_rd_en
//   drv_rgb             shared pixel bus to every driver
//   drv_rgb_valid[U]    one-hot qualifier of drv_rgb
//   overrun_count       saturating count of dropped frames
module frame_scheduler #(
    parameter int unsigned UNIVERSES = 16,
    parameter int unsigned CLOCK     = 50000000,
    parameter int unsigned FPS       = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UNIVERSES-1:0]   frame_ready,
    input  logic [UNIVERSES-1:0]   drv_sending,
    input  logic [UNIVERSES-1:0]   drv_request,
    input  logic [UNIVERSES*8-1:0] drv_addr,
    output logic [UNIVERSES-1:0]   drv_start,
    output logic                   mem_rd_en,
    output logic [3:0]             mem_rd_univ,
    output logic [7:0]             mem_rd_addr,
    input  logic [23:0]            mem_rd_data,
    output logic [23:0]            drv_rgb,
    output logic [UNIVERSES-1:0]   drv_rgb_valid,
    output logic [7:0]             overrun_count
);

    localparam int unsigned TICK  = CLOCK / FPS;
    localparam int unsigned CNT_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int unsigned IDX_W = (UNIVERSES > 1) ? $clog2(UNIVERSES) : 1;
    localparam int unsigned POP_W = $clog2(UNIVERSES + 1);

    // ---------------- state ----------------
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [UNIVERSES-1:0] pending_q, pending_d;
    logic [UNIVERSES-1:0] start_q, start_d;
    logic [7:0]           overrun_q, overrun_d;

    logic [UNIVERSES-1:0] req_pending_q, req_pending_d;
    logic [7:0]           addr_hold_q [UNIVERSES];
    logic [7:0]           addr_hold_d [UNIVERSES];
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic                 rd_en_q, rd_en_d;
    logic [IDX_W-1:0]     rd_univ_q, rd_univ_d;
    logic [7:0]           rd_addr_q, rd_addr_d;
    logic                 resp_vld_q;
    logic [IDX_W-1:0]     resp_univ_q;
    logic [23:0]          rgb_q, rgb_d;
    logic [UNIVERSES-1:0] rgb_valid_q, rgb_valid_d;

    // ---------------- combinational helpers ----------------
    logic                 frame_tick;
    logic [UNIVERSES-1:0] ovr_vec;
    logic [POP_W-1:0]     ovr_num;
    logic [8:0]           ovr_sum;

    logic [7:0]           drv_addr_a [UNIVERSES];
    logic [UNIVERSES-1:0] eligible;
    logic [UNIVERSES-1:0] grant_oh;
    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [7:0]           grant_addr;

    for (genvar g = 0; g < UNIVERSES; g++) begin : g_addr
        assign drv_addr_a[g] = drv_addr[8*g +: 8];
    end

    assign frame_tick = (tick_cnt_q == CNT_W'(TICK - 1));

    // Frame pacing: start every idle universe with a loaded frame on the tick.
    always_comb begin
        tick_cnt_d = frame_tick ? '0 : tick_cnt_q + CNT_W'(1);
        start_d    = frame_tick ? (pending_q & ~drv_sending) : '0;
        // A fresh frame_ready wins over the clearing tick and is not a drop.
        pending_d  = (pending_q & ~start_d) | frame_ready;
        ovr_vec    = frame_ready & pending_q & ~start_d;
        ovr_num    = '0;
        for (int i = 0; i < UNIVERSES; i++) begin
            ovr_num = ovr_num + POP_W'(ovr_vec[i]);
        end
        ovr_sum   = {1'b0, overrun_q} + 9'(ovr_num);
        overrun_d = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
    end

    // Round-robin arbiter. A request arriving this cycle is eligible at once,
    // which keeps the request-to-data latency within UNIVERSES+2 cycles.
    always_comb begin : arb_comb
        int unsigned cand;
        cand        = 0;
        eligible    = req_pending_q | drv_request;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        for (int unsigned k = 0; k < UNIVERSES; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= UNIVERSES) begin
                cand = cand - UNIVERSES;
            end
            if (!grant_found && eligible[IDX_W'(cand)]) begin
                grant_found             = 1'b1;
                grant_idx               = IDX_W'(cand);
                grant_oh[IDX_W'(cand)]  = 1'b1;
            end
        end
        // An older latched request is served first with its held address.
        grant_addr = req_pending_q[grant_idx] ? addr_hold_q[grant_idx]
                                              : drv_addr_a[grant_idx];
    end

    // Request bookkeeping and read pipeline next state.
    always_comb begin
        // A new request is consumed directly only if nothing older was waiting.
        req_pending_d = (req_pending_q & ~grant_oh)
                      | (drv_request & ~(grant_oh & ~req_pending_q));
        for (int i = 0; i < UNIVERSES; i++) begin
            addr_hold_d[i] = drv_request[i] ? drv_addr_a[i] : addr_hold_q[i];
        end
        rr_ptr_d  = rr_ptr_q;
        rd_univ_d = rd_univ_q;
        rd_addr_d = rd_addr_q;
        rd_en_d   = grant_found;
        if (grant_found) begin
            rr_ptr_d  = (grant_idx == IDX_W'(UNIVERSES - 1)) ? '0
                                                             : grant_idx + IDX_W'(1);
            rd_univ_d = grant_idx;
            rd_addr_d = grant_addr;
        end
        rgb_d       = resp_vld_q ? mem_rd_data : rgb_q;
        rgb_valid_d = resp_vld_q ? (UNIVERSES'(1) << resp_univ_q) : '0;
    end

    // All state; reset also discards any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q    <= '0;
            pending_q     <= '0;
            start_q       <= '0;
            overrun_q     <= '0;
            req_pending_q <= '0;
            for (int i = 0; i < UNIVERSES; i++) begin
                addr_hold_q[i] <= '0;
            end
            rr_ptr_q      <= '0;
            rd_en_q       <= 1'b0;
            rd_univ_q     <= '0;
            rd_addr_q     <= '0;
            resp_vld_q    <= 1'b0;
            resp_univ_q   <= '0;
            rgb_q         <= '0;
            rgb_valid_q   <= '0;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            pending_q     <= pending_d;
            start_q       <= start_d;
            overrun_q     <= overrun_d;
            req_pending_q <= req_pending_d;
            for (int i = 0; i < UNIVERSES; i++) begin
                addr_hold_q[i] <= addr_hold_d[i];
            end
            rr_ptr_q      <= rr_ptr_d;
            rd_en_q       <= rd_en_d;
            rd_univ_q     <= rd_univ_d;
            rd_addr_q     <= rd_addr_d;
            resp_vld_q    <= rd_en_q;
            resp_univ_q   <= rd_univ_q;
            rgb_q         <= rgb_d;
            rgb_valid_q   <= rgb_valid_d;
        end
    end

    assign drv_start     = start_q;
    assign overrun_count = overrun_q;
    assign mem_rd_en     = rd_en_q;
    assign mem_rd_univ   = 4'(rd_univ_q);
    assign mem_rd_addr   = rd_addr_q;
    assign drv_rgb       = rgb_q;
    assign drv_rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Testbench for frame_scheduler: directed scenarios plus random traffic,
// all compared cycle by cycle against a behavioural model.
module tb_frame_scheduler;

    localparam int U    = 16;
    localparam int TICK = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   frame_ready = '0;
    logic [15:0]   drv_sending = '0;
    logic [15:0]   drv_request = '0;
    logic [127:0]  drv_addr = '0;
    logic [15:0]   drv_start;
    logic          mem_rd_en;
    logic [3:0]    mem_rd_univ;
    logic [7:0]    mem_rd_addr;
    logic [23:0]   mem_rd_data = '0;
    logic [23:0]   drv_rgb;
    logic [15:0]   drv_rgb_valid;
    logic [7:0]    overrun_count;

    frame_scheduler #(.UNIVERSES(U), .CLOCK(100), .FPS(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_ready   (frame_ready),
        .drv_sending   (drv_sending),
        .drv_request   (drv_request),
        .drv_addr      (drv_addr),
        .drv_start     (drv_start),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_univ   (mem_rd_univ),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .drv_rgb       (drv_rgb),
        .drv_rgb_valid (drv_rgb_valid),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    bit          m_pend [U];   // frame loaded, waiting for a tick
    bit          m_preq [U];   // pixel request waiting for the memory
    logic [7:0]  m_hold [U];
    int          m_last;       // last universe served
    int          m_ovr;
    int          m_n;          // cycles since reset release
    logic [15:0] e_start, e_valid;
    logic        e_en;
    logic [3:0]  e_univ;
    logic [7:0]  e_addr;
    logic [23:0] e_rgb;
    logic        m_resp_en;
    int          m_resp_univ;
    logic [7:0]  m_resp_addr;

    function automatic logic [23:0] memf(int u, logic [7:0] a);
        return {a, 8'(u * 37 + 11), a ^ 8'hA5};
    endfunction

    task automatic model_reset();
        for (int u = 0; u < U; u++) begin
            m_pend[u] = 0; m_preq[u] = 0; m_hold[u] = '0;
        end
        m_last = U - 1; m_ovr = 0; m_n = 0;
        e_start = '0; e_valid = '0; e_en = 0; e_univ = '0; e_addr = '0; e_rgb = '0;
        m_resp_en = 0; m_resp_univ = 0; m_resp_addr = '0;
    endtask

    // Called at a falling edge: compare this cycle, drive inputs, advance model.
    task automatic step(input logic [15:0] fr, input logic [15:0] snd,
                        input logic [15:0] req, input logic [127:0] addr);
        logic [23:0] md;
        logic [15:0] n_start, n_valid;
        logic [23:0] n_rgb;
        logic [7:0]  a;
        bit          tick;
        int          g;
        check("drv_start", 32'(drv_start), 32'(e_start));
        check("mem_rd_en", 32'(mem_rd_en), 32'(e_en));
        check("mem_rd_univ", 32'(mem_rd_univ), 32'(e_univ));
        check("mem_rd_addr", 32'(mem_rd_addr), 32'(e_addr));
        check("drv_rgb", 32'(drv_rgb), 32'(e_rgb));
        check("drv_rgb_valid", 32'(drv_rgb_valid), 32'(e_valid));
        check("overrun_count", 32'(overrun_count), 32'(m_ovr));

        md = m_resp_en ? memf(m_resp_univ, m_resp_addr) : 24'($urandom);
        frame_ready = fr; drv_sending = snd; drv_request = req; drv_addr = addr;
        mem_rd_data = md;

        n_valid = m_resp_en ? (16'(1) << m_resp_univ) : '0;
        n_rgb   = m_resp_en ? md : e_rgb;
        m_resp_en = e_en; m_resp_univ = int'(e_univ); m_resp_addr = e_addr;

        tick = (m_n % TICK) == TICK - 1;
        for (int u = 0; u < U; u++) begin
            n_start[u] = tick && m_pend[u] && !snd[u];
            if (fr[u] && m_pend[u] && !n_start[u]) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
            m_pend[u] = fr[u] || (m_pend[u] && !n_start[u]);
        end

        g = -1;
        for (int k = 1; k <= U; k++) begin
            int u;
            u = (m_last + k) % U;
            if (g < 0 && (m_preq[u] || req[u])) g = u;
        end
        e_en = (g >= 0);
        if (g >= 0) begin
            a = addr[g*8 +: 8];
            e_univ = 4'(g);
            e_addr = m_preq[g] ? m_hold[g] : a;
            m_last = g;
        end
        for (int u = 0; u < U; u++) begin
            if (u == g) m_preq[u] = m_preq[u] && req[u];
            else        m_preq[u] = m_preq[u] || req[u];
            if (req[u]) m_hold[u] = addr[u*8 +: 8];
        end

        e_start = n_start; e_valid = n_valid; e_rgb = n_rgb;
        m_n++;
        @(negedge clk);
    endtask

    // Entered at a falling edge; leaves at the falling edge of release.
    task automatic do_reset();
        rst_n = 0;
        frame_ready = '0; drv_sending = '0; drv_request = '0; drv_addr = '0; mem_rd_data = '0;
        #1;
        check("rst_drv_start", 32'(drv_start), 32'h0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'h0);
        check("rst_mem_rd_univ", 32'(mem_rd_univ), 32'h0);
        check("rst_mem_rd_addr", 32'(mem_rd_addr), 32'h0);
        check("rst_drv_rgb", 32'(drv_rgb), 32'h0);
        check("rst_drv_rgb_valid", 32'(drv_rgb_valid), 32'h0);
        check("rst_overrun", 32'(overrun_count), 32'h0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    function automatic logic [15:0] rand_bits(int pct);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < U; i++) if (int'($urandom_range(99)) < pct) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [127:0] rand_addr();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] ad;
        int max_lat, served, fair_ok, seen;
        int cnt [U];
        model_reset();
        @(negedge clk);

        // Frame timing: one start after the first tick, none after the second.
        do_reset();
        for (int c = 0; c < 210; c++) begin
            if (c == 100) check("start_after_tick", 32'(drv_start), 32'h0008);
            if (c == 200) check("no_second_start", 32'(drv_start), 32'h0000);
            step((c == 10) ? 16'h0008 : 16'h0, '0, '0, rand_addr());
        end

        // Deferral while the driver is busy.
        do_reset();
        for (int c = 0; c < 230; c++) begin
            if (c == 100) check("deferred_no_start", 32'(drv_start), 32'h0000);
            if (c == 200) check("deferred_start", 32'(drv_start), 32'h0020);
            step((c == 5) ? 16'h0020 : 16'h0, (c < 150) ? 16'h0020 : 16'h0, '0, rand_addr());
        end

        // Overrun counting and saturation.
        do_reset();
        for (int c = 0; c <= 550; c++) begin
            if (c == 30)  check("overrun_one", 32'(overrun_count), 32'd1);
            if (c == 550) check("overrun_sat", 32'(overrun_count), 32'd255);
            step((c == 10 || c == 20 || (c >= 50 && c < 550)) ? 16'h0001 : 16'h0, '0, '0, rand_addr());
        end

        // Arbitration order for universes 0, 7, 15.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            if (c == 4) check("arb_rd0", {mem_rd_en, 19'd0, mem_rd_univ, mem_rd_addr}, {1'b1, 19'd0, 4'd0, 8'd1});
            if (c == 5) check("arb_rd1", {mem_rd_en, 19'd0, mem_rd_univ, mem_rd_addr}, {1'b1, 19'd0, 4'd7, 8'd2});
            if (c == 6) check("arb_rd2", {mem_rd_en, 19'd0, mem_rd_univ, mem_rd_addr}, {1'b1, 19'd0, 4'd15, 8'd3});
            if (c == 7) check("arb_idle", 32'(mem_rd_en), 32'd0);
            if (c == 6) check("arb_v0", {8'd0, drv_rgb_valid[15:8], drv_rgb[15:0]}, {8'd0, 8'h00, memf(0, 8'd1) & 24'h00FFFF} & 32'h00FFFFFF);
            if (c == 6) check("arb_valid0", 32'(drv_rgb_valid), 32'h0001);
            if (c == 7) check("arb_valid7", 32'(drv_rgb_valid), 32'h0080);
            if (c == 8) check("arb_valid15", 32'(drv_rgb_valid), 32'h8000);
            if (c == 8) check("arb_rgb15", 32'(drv_rgb), 32'(memf(15, 8'd3)));
            ad = rand_addr();
            if (c == 3) begin
                ad[7:0] = 8'd1; ad[63:56] = 8'd2; ad[127:120] = 8'd3;
            end
            step('0, '0, (c == 3) ? 16'h8081 : 16'h0, ad);
        end

        // All universes request together: worst-case latency.
        do_reset();
        max_lat = 0; served = 0;
        for (int c = 0; c < 30; c++) begin
            for (int u = 0; u < U; u++) if (drv_rgb_valid[u]) begin
                served++;
                if (c - 2 > max_lat) max_lat = c - 2;
            end
            step('0, '0, (c == 2) ? 16'hFFFF : 16'h0, rand_addr());
        end
        check("burst_served", 32'(served), 32'd16);
        check("latency_bound", 32'(max_lat <= U + 2), 32'd1);

        // Continuous requests: each universe served once per 16 cycles.
        do_reset();
        for (int u = 0; u < U; u++) cnt[u] = 0;
        for (int c = 0; c < 100; c++) begin
            if (c >= 20 && c < 84)
                for (int u = 0; u < U; u++) if (drv_rgb_valid[u]) cnt[u]++;
            step('0, '0, 16'hFFFF, rand_addr());
        end
        fair_ok = 0;
        for (int u = 0; u < U; u++) if (cnt[u] == 4) fair_ok++;
        check("fairness", 32'(fair_ok), 32'd16);

        // Random traffic.
        do_reset();
        for (int c = 0; c < 3000; c++)
            step(rand_bits(2), rand_bits(50), rand_bits(12), rand_addr());

        // Reset one cycle after a read for universe 4 is issued.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) check("pre_reset_rd", {mem_rd_en, 27'd0, mem_rd_univ}, {1'b1, 27'd0, 4'd4});
            step('0, '0, (c == 1) ? 16'h0010 : 16'h0, {$urandom, $urandom, $urandom, 24'h0, 8'h44});
        end
        do_reset();
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (drv_rgb_valid[4]) seen++;
            step('0, '0, '0, rand_addr());
        end
        check("no_stale_valid", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
